// File: rtl/codificador_pt2262.sv
// PT2262-style trinary serial encoder: 8 address symbols (0/1/F),
// 4 data bits and a sync word per 512-chip frame, repeated in bursts.
//
// Ports:
//   clk        system clock (3 MHz nominal)
//   reset      asynchronous, active-high
//   A_01[7:0]  address bit value per symbol (A_01[0] sent first)
//   A_F[7:0]   address float flags; a set flag sends F for that symbol
//   D[3:0]     data nibble, D[3] sent first
//   send       level request, sampled only on chip ticks
//   cod_o      registered serial output
//   busy       high while a frame is in progress
//   frame_done one-cycle pulse after each frame's last sync chip
//              (present only when ENC_FRAME_DONE_EN is defined)
//
// Parameters:
//   DIV        clk cycles per chip, at least 2
//   MIN_FRAMES minimum frames per request, 1..15

module codificador_pt2262 #(
  parameter int DIV        = 250,
  parameter int MIN_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] A_01,
  input  logic [7:0] A_F,
  input  logic [3:0] D,
  input  logic       send,
  output logic       cod_o,
`ifdef ENC_FRAME_DONE_EN
  output logic       frame_done,
`endif
  output logic       busy
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    SYNC
  } state_t;

  // chip-rate prescaler
  logic [PW-1:0] pre;
  logic          tick;

  // frame sequencing state
  state_t     state, n_state;
  logic [2:0] sym,   n_sym;
  logic [4:0] chip,  n_chip;
  logic [3:0] frames, n_frames;

  // inputs captured at each frame start
  logic [7:0] a01_q, n_a01;
  logic [7:0] af_q,  n_af;
  logic [3:0] d_q,   n_d;

  logic frame_end;
  logic start;
  logic cod_d;

  assign tick = (pre == PW'(DIV - 1));

  // ------------------------------------------------------------
  // State register
  // ------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre    <= '0;
      state  <= IDLE;
      sym    <= '0;
      chip   <= '0;
      frames <= '0;
      a01_q  <= '0;
      af_q   <= '0;
      d_q    <= '0;
      cod_o  <= 1'b0;
    end else begin
      if (tick) begin
        pre <= '0;
      end else begin
        pre <= pre + PW'(1);
      end
      state  <= n_state;
      sym    <= n_sym;
      chip   <= n_chip;
      frames <= n_frames;
      a01_q  <= n_a01;
      af_q   <= n_af;
      d_q    <= n_d;
      if (tick) begin
        cod_o <= cod_d;
      end
    end
  end

`ifdef ENC_FRAME_DONE_EN
  // frame_end is only ever raised on a tick, so this is a
  // single-cycle pulse following that tick edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
    end
  end
`endif

  // ------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------
  always_comb begin
    n_state   = state;
    n_sym     = sym;
    n_chip    = chip;
    n_frames  = frames;
    n_a01     = a01_q;
    n_af      = af_q;
    n_d       = d_q;
    frame_end = 1'b0;
    start     = 1'b0;

    if (tick) begin
      unique case (state)
        IDLE: begin
          start = send;
        end
        default: begin
          n_chip = chip + 5'd1;
          if (chip == 5'd31) begin
            unique case (state)
              ADDR: begin
                if (sym == 3'd7) begin
                  n_state = DATA;
                  n_sym   = 3'd3;
                end else begin
                  n_sym = sym + 3'd1;
                end
              end
              DATA: begin
                if (sym == 3'd0) begin
                  n_state = SYNC;
                  n_sym   = 3'd0;
                end else begin
                  n_sym = sym - 3'd1;
                end
              end
              SYNC: begin
                if (sym == 3'd3) begin
                  frame_end = 1'b1;
                end else begin
                  n_sym = sym + 3'd1;
                end
              end
              default: begin
              end
            endcase
          end
        end
      endcase
    end

    // Burst accounting: the count saturates so a held request
    // keeps repeating without overflow.
    if (frame_end) begin
      if (frames < 4'(MIN_FRAMES)) begin
        n_frames = frames + 4'd1;
      end
      if (send || (n_frames < 4'(MIN_FRAMES))) begin
        start = 1'b1;
      end else begin
        n_state  = IDLE;
        n_sym    = 3'd0;
        n_chip   = 5'd0;
        n_frames = 4'd0;
      end
    end

    if (start) begin
      n_state = ADDR;
      n_sym   = 3'd0;
      n_chip  = 5'd0;
      n_a01   = A_01;
      n_af    = A_F;
      n_d     = D;
    end
  end

  // ------------------------------------------------------------
  // Output logic
  // ------------------------------------------------------------
  // cod_d is the level of the chip that the next tick moves into,
  // so cod_o is registered yet aligned with the chip counter.
  always_comb begin
    logic hi_s;
    logic hi_l;
    logic flt;
    logic bv;

    hi_s = (n_chip[3:0] < 4'd4);
    hi_l = (n_chip[3:0] < 4'd12);
    flt  = 1'b0;
    bv   = 1'b0;
    cod_d = 1'b0;

    unique case (n_state)
      IDLE: begin
        cod_d = 1'b0;
      end
      ADDR: begin
        flt = n_af[n_sym];
        bv  = n_a01[n_sym];
        if (flt) begin
          // F: first half like a 0, second half like a 1
          cod_d = n_chip[4] ? hi_l : hi_s;
        end else begin
          cod_d = bv ? hi_l : hi_s;
        end
      end
      DATA: begin
        bv    = n_d[n_sym[1:0]];
        cod_d = bv ? hi_l : hi_s;
      end
      SYNC: begin
        // 4 high chips, then 124 low over the 4 sync words
        cod_d = (n_sym == 3'd0) && (n_chip < 5'd4);
      end
    endcase

    busy = (state != IDLE);
  end

endmodule

// File: tb/tb_codificador_pt2262.sv
// Directed bench for codificador_pt2262: frames are sampled chip
// by chip and compared symbol-wise against hand-coded expectations.

module tb_codificador_pt2262;

  localparam int DIV = 3;
  localparam int MINF = 4;

  logic       clk;
  logic       reset;
  logic [7:0] A_01;
  logic [7:0] A_F;
  logic [3:0] D;
  logic       send;
  logic       cod_o;
  logic       busy;
`ifdef ENC_FRAME_DONE_EN
  logic       frame_done;
`endif

  int nvec = 0;
  int nerr = 0;

  codificador_pt2262 #(
    .DIV        (DIV),
    .MIN_FRAMES (MINF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .A_01       (A_01),
    .A_F        (A_F),
    .D          (D),
    .send       (send),
    .cod_o      (cod_o),
`ifdef ENC_FRAME_DONE_EN
    .frame_done (frame_done),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // syms: 12 two-bit codes, first symbol in [23:22];
  // 0 = bit 0, 1 = bit 1, 2 = float
  typedef struct {
    logic [7:0]  a01;
    logic [7:0]  af;
    logic [3:0]  d;
    logic [23:0] syms;
  } vec_t;

  vec_t tbl[6];

  function automatic logic [31:0] symw(input logic [1:0] c);
    case (c)
      2'd0:    symw = 32'hF000F000;
      2'd1:    symw = 32'hFFF0FFF0;
      default: symw = 32'hF000FFF0;
    endcase
  endfunction

  task automatic chk(input string nm,
                     input logic [32:0] got,
                     input logic [32:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  // Waits (bounded) for busy, then samples every chip of nfr
  // frames at the first falling edge inside the chip.
  task automatic burst(input int nfr,
                       input vec_t e1,
                       input vec_t e2,
                       input int drop_f,
                       input bit chg,
                       input logic [3:0] newd,
                       output int lat);
    logic [31:0] w;
    logic [31:0] ew;
    logic        ball;
    vec_t        e;
    lat = 0;
    while (!busy && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!busy) begin
      chk("start_timeout", 33'(busy), 33'd1);
      return;
    end
    for (int f = 0; f < nfr; f++) begin
      e = (f == 0) ? e1 : e2;
      for (int s = 0; s < 16; s++) begin
        w = '0;
        ball = 1'b1;
        for (int c = 0; c < 32; c++) begin
          if (f == drop_f && s == 0 && c == 5)
            send = 1'b0;
          if (chg && f == 0 && s == 1 && c == 18)
            D = newd;
          w = {w[30:0], cod_o};
          ball = ball & busy;
          repeat (DIV) @(negedge clk);
        end
        if (s < 12)
          ew = symw(e.syms[(11-s)*2 +: 2]);
        else if (s == 12)
          ew = 32'hF0000000;
        else
          ew = 32'h0;
        chk($sformatf("frame%0d_sym%0d", f, s),
            {ball, w}, {1'b1, ew});
      end
    end
    chk("end_idle", {31'd0, busy, cod_o}, 33'd0);
    repeat (8 * DIV) @(negedge clk);
    chk("stay_idle", {31'd0, busy, cod_o}, 33'd0);
  endtask

  initial begin
    int lat;
    int n;

    tbl[0] = '{8'h05, 8'h80, 4'hA,
      24'b01_00_01_00_00_00_00_10_01_00_01_00};
    tbl[1] = '{8'hFF, 8'h00, 4'h5,
      24'b01_01_01_01_01_01_01_01_00_01_00_01};
    tbl[2] = '{8'h00, 8'hFF, 4'hF,
      24'b10_10_10_10_10_10_10_10_01_01_01_01};
    tbl[3] = '{8'hC3, 8'h81, 4'h0,
      24'b10_01_00_00_00_00_01_10_00_00_00_00};
    tbl[4] = '{8'h05, 8'h80, 4'h3,
      24'b01_00_01_00_00_00_00_10_00_00_01_01};
    tbl[5] = '{8'h05, 8'h80, 4'hC,
      24'b01_00_01_00_00_00_00_10_01_01_00_00};

    reset = 1'b1;
    send  = 1'b0;
    A_01  = '0;
    A_F   = '0;
    D     = '0;
    repeat (4) @(negedge clk);
    chk("reset_state", {31'd0, busy, cod_o}, 33'd0);
    reset = 1'b0;
    repeat (2 * DIV) @(negedge clk);

    // short request -> exactly MIN_FRAMES frames each
    for (int v = 0; v < 4; v++) begin
      A_01 = tbl[v].a01;
      A_F  = tbl[v].af;
      D    = tbl[v].d;
      send = 1'b1;
      burst(MINF, tbl[v], tbl[v], 0, 1'b0, 4'h0, lat);
    end

    // held request: dropped during frame 8 -> 8 frames
    A_01 = tbl[0].a01;
    A_F  = tbl[0].af;
    D    = tbl[0].d;
    send = 1'b1;
    burst(8, tbl[0], tbl[0], 7, 1'b0, 4'h0, lat);

    // data change mid-address of frame 1
    A_01 = tbl[4].a01;
    A_F  = tbl[4].af;
    D    = tbl[4].d;
    send = 1'b1;
    burst(MINF, tbl[4], tbl[5], 0, 1'b1, 4'hC, lat);

    // asynchronous reset at chip 200 of frame 2
    A_01 = tbl[1].a01;
    A_F  = tbl[1].af;
    D    = tbl[1].d;
    send = 1'b1;
    n = 0;
    while (!busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    send = 1'b0;
    repeat ((512 + 200) * DIV) @(negedge clk);
    chk("pre_reset_active", {31'd0, busy, cod_o}, 33'd3);
    #1 reset = 1'b1;
    #1;
    chk("async_reset", {31'd0, busy, cod_o}, 33'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (40 * DIV) @(negedge clk);
    chk("no_output_after_reset", {31'd0, busy, cod_o}, 33'd0);

    // first tick lands DIV cycles after reset release
    reset = 1'b1;
    @(negedge clk);
    send  = 1'b1;
    reset = 1'b0;
    burst(MINF, tbl[1], tbl[1], 0, 1'b0, 4'h0, lat);
    chk("first_tick_latency", 33'(lat), 33'(DIV));

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
